// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared write-back constants, arbitration state encoding and age helper.
package wb_arbiter_pkg;
    localparam int W_DATA_DEF     = 32;
    localparam int W_REG_DEF      = 4;
    localparam int DEPTH_DEF      = 2;
    localparam int STARVE_MAX_DEF = 2;

    typedef enum logic {LD_PRI = 1'b0, ALU_PRI = 1'b1} arb_state_e;

    // Sequence numbers wrap mod 8; ALU is older when load issued 1..3 slots later.
    function automatic logic alu_is_older(input logic [2:0] alu_seq, input logic [2:0] ld_seq);
        logic [2:0] d;
        d = ld_seq - alu_seq;
        return d inside {3'd1, 3'd2, 3'd3};
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: per-requester buffer; ready depends only on occupancy, so a full FIFO never accepts.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    output logic         ready_o,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign ready_o = cnt_q < CW'(DEPTH);
    assign valid_o = cnt_q != '0;
    assign dout_o  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        do_push = push_i & ready_o;
        do_pop  = pop_i & valid_o;
        if (do_push) mem_d[wr_q] = din_i;
        wr_d  = do_push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = do_pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load results onto one register-file write port,
// keeping same-register writes in age order and bounding ALU starvation.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int W_DATA     = W_DATA_DEF,
    parameter int W_REG      = W_REG_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    input  logic [W_REG-1:0]  alu_r_i,
    input  logic [W_DATA-1:0] alu_data_i,
    input  logic [2:0]        alu_seq_i,
    output logic              alu_ready_o,
    input  logic              ld_valid_i,
    input  logic [W_REG-1:0]  ld_r_i,
    input  logic [W_DATA-1:0] ld_data_i,
    input  logic [2:0]        ld_seq_i,
    output logic              ld_ready_o,
    output logic              wb_o,
    output logic [W_REG-1:0]  wb_r_o,
    output logic [W_DATA-1:0] wb_data_o,
    output logic              stall_o
);
    localparam int EW = W_REG + W_DATA + 3;

    logic [EW-1:0]     alu_head, ld_head;
    logic              alu_hv, ld_hv, grant_alu, grant_ld;
    logic [W_REG-1:0]  alu_hr, ld_hr;
    arb_state_e        state_q, state_d;
    logic [1:0]        starve_q, starve_d;
    logic              wb_q, wb_d;
    logic [W_REG-1:0]  wb_r_q, wb_r_d;
    logic [W_DATA-1:0] wb_data_q, wb_data_d;

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst),
        .push_i(alu_valid_i), .din_i({alu_r_i, alu_data_i, alu_seq_i}), .ready_o(alu_ready_o),
        .pop_i(grant_alu), .dout_o(alu_head), .valid_o(alu_hv)
    );

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_ld_fifo (
        .clk(clk), .rst(rst),
        .push_i(ld_valid_i), .din_i({ld_r_i, ld_data_i, ld_seq_i}), .ready_o(ld_ready_o),
        .pop_i(grant_ld), .dout_o(ld_head), .valid_o(ld_hv)
    );

    assign alu_hr    = alu_head[EW-1 -: W_REG];
    assign ld_hr     = ld_head[EW-1 -: W_REG];
    assign stall_o   = ~alu_ready_o | ~ld_ready_o;
    assign wb_o      = wb_q;
    assign wb_r_o    = wb_r_q;
    assign wb_data_o = wb_data_q;

    // Same-register conflicts are resolved by age before the priority state is consulted.
    always_comb begin
        grant_alu = alu_hv & (~ld_hv | ((alu_hr == ld_hr) ? alu_is_older(alu_head[2:0], ld_head[2:0])
                                                          : (state_q == ALU_PRI)));
        grant_ld  = ld_hv & ~grant_alu;
        starve_d  = grant_alu ? 2'd0 : (alu_hv & grant_ld & (starve_q != 2'd3)) ? starve_q + 2'd1 : starve_q;
        state_d   = grant_alu ? LD_PRI : (int'(starve_d) >= STARVE_MAX) ? ALU_PRI : state_q;
        wb_d      = grant_alu | grant_ld;
        wb_r_d    = grant_alu ? alu_hr : grant_ld ? ld_hr : wb_r_q;
        wb_data_d = grant_alu ? alu_head[W_DATA+2:3] : grant_ld ? ld_head[W_DATA+2:3] : wb_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LD_PRI;
            starve_q  <= '0;
            wb_q      <= 1'b0;
            wb_r_q    <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wb_q      <= wb_d;
            wb_r_q    <= wb_r_d;
            wb_data_q <= wb_data_d;
        end
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be: W_DATA, default 32, write-back data width; W_REG, default 4, register address width; DEPTH, default 2, per-requester buffer entries; STARVE_MAX, default 2, consecutive ALU losses before ALU priority.
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  clock; one clock domain
  rst  in  1  reset, asynchronous, active-low
  alu_valid_i  in  1  ALU result request
  alu_r_i  in  W_REG  ALU target register
  alu_data_i  in  W_DATA  ALU result
  alu_seq_i  in  3  ALU issue sequence number
  alu_ready_o  out  1  ALU buffer can accept
  ld_valid_i  in  1  load result request
  ld_r_i  in  W_REG  load target register
  ld_data_i  in  W_DATA  load data
  ld_seq_i  in  3  load issue sequence number
  ld_ready_o  out  1  load buffer can accept
  wb_o  out  1  write-back enable to register file
  wb_r_o  out  W_REG  write-back register
  wb_data_o  out  W_DATA  write-back data
  stall_o  out  1  back-pressure to decode

Function
REQ-003 Each requester SHALL own a DEPTH-entry FIFO holding {r, data, seq}; a push SHALL occur on a clock edge where valid_i and ready_o are both 1.
REQ-004 ready_o SHALL be 1 exactly when that FIFO count < DEPTH, computed from count only and independent of valid_i; no push SHALL occur while full, even on a pop edge.
REQ-005 stall_o SHALL be ~alu_ready_o | ~ld_ready_o.
REQ-006 At most one FIFO head SHALL be popped per edge; the popped head SHALL be registered into wb_r_o/wb_data_o with wb_o=1 in the following cycle.
REQ-007 With no head available, wb_o SHALL be 0 the next cycle; wb_r_o/wb_data_o SHALL hold their last values.
REQ-008 Latency SHALL be 2 cycles: a request accepted at edge E into an empty, uncontended FIFO appears on wb_o after edge E+1.
REQ-009 The arbitration FSM SHALL have states LD_PRI (reset state) and ALU_PRI.
REQ-010 With one head valid, that head SHALL be granted regardless of state.
REQ-011 With both heads valid and equal target registers, the older head SHALL win; the ALU head is older when (ld_seq - alu_seq) mod 8 is in 1..3. Equal seq SHALL favour load. This rule SHALL override the FSM state.
REQ-012 Otherwise, with both heads valid, LD_PRI SHALL grant load and ALU_PRI SHALL grant ALU.
REQ-013 Starve counter (2 bits) behaviour:
  - SHALL increment on each edge where ALU has a valid head and load is granted.
  - SHALL clear on any ALU grant.
  - On reaching STARVE_MAX, the FSM SHALL go LD_PRI->ALU_PRI.
  - An ALU grant SHALL return ALU_PRI->LD_PRI.
REQ-014 Per-FIFO order SHALL be strict FIFO; pointers SHALL wrap modulo DEPTH.
REQ-015 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged and keep data order.

Reset
REQ-016 While rst=0, the following SHALL hold immediately:
  - wb_o=0, wb_r_o=0, wb_data_o=0
  - FIFOs empty, starve counter 0, FSM=LD_PRI
  - alu_ready_o=ld_ready_o=1, stall_o=0
REQ-017 Reset mid-operation SHALL discard all buffered entries; no wb_o pulse SHALL follow reset release without a new push.

Structure
REQ-018 W_DATA, W_REG, DEPTH, STARVE_MAX and the FSM state encoding SHALL live in the shared CPU constants include.
REQ-019 The per-requester buffer SHALL be one sub-module, wb_fifo, instantiated twice.

Verification
REQ-020 Single ALU write: alu r=3, data=32'hDEAD_BEEF at edge 0 -> wb_o=1, wb_r_o=3, wb_data_o=32'hDEADBEEF after edge 1, wb_o=0 after edge 2.
REQ-021 Starvation: both FIFOs kept non-empty, distinct registers -> grant sequence LD, LD, ALU, LD, LD, ALU.
REQ-022 Same-register ordering: alu r=5 seq=6 and ld r=5 seq=1 pushed on the same edge -> ALU written first (wrap-around older), load second.
REQ-023 Full: 2 load pushes with no pops -> ld_ready_o=0 and stall_o=1; a third valid is not accepted; one pop restores ready the next cycle.
REQ-024 Reset mid-stream: assert rst with 2 entries buffered -> outputs 0 immediately; after release, wb_o stays 0 until a new push.
